// File: rtl/fsm_lock_core.sv
// Password lock: i_CE tick divider, synchronised digit entry, code check, fail/lockout timing.
// Optional CODE_PROG_EN: code held in a register and reprogrammable from OPEN via i_prog.
module fsm_lock_core #(
  parameter int DIGIT_W       = 4,
  parameter int CODE_LEN      = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int DIV           = 5_000_000,
  parameter int OPEN_TICKS    = 6,
  parameter int FAIL_TICKS    = 2,
  parameter int MAX_FAIL      = 3,
  parameter int LOCKOUT_TICKS = 20,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                          clk,
  input  logic                          i_Rst,
  input  logic                          i_CE,
  input  logic                          i_set_data,
  input  logic [DIGIT_W-1:0]            iv_data,
`ifdef CODE_PROG_EN
  input  logic                          i_prog,
`endif
  output logic [7:0]                    o_acknowledge,
  output logic                          o_locked,
  output logic                          o_open,
  output logic [$clog2(MAX_FAIL+1)-1:0] ov_fail_cnt
);
  localparam int CW  = CODE_LEN * DIGIT_W;
  localparam int DCW = $clog2(CODE_LEN + 1);
  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam int DVW = $clog2(DIV);
  localparam int T1  = (OPEN_TICKS > FAIL_TICKS) ? OPEN_TICKS : FAIL_TICKS;
  localparam int T2  = (LOCKOUT_TICKS > TIMEOUT_TICKS) ? LOCKOUT_TICKS : TIMEOUT_TICKS;
  localparam int TW  = $clog2(((T1 > T2) ? T1 : T2) + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  logic [2:0]     r_state, w_nstate;
  logic [DVW-1:0] r_div;
  logic [1:0]     r_sync;
  logic           r_sync_d, r_edge;
  logic [TW-1:0]  r_tmr;
  logic [DCW-1:0] r_cnt, w_cnt;
  logic [CW-1:0]  r_digits, w_digits, w_code;
  logic [FCW-1:0] r_fail, w_fail, r_fail_q;
  logic           r_fph, w_tmr_clr, w_pause, w_tick, w_prog_led;
  logic [7:0]     r_ack, w_therm;
  logic           r_locked, r_open;

  assign w_tick = i_CE && (r_div == DVW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (i_Rst) r_div <= '0;
    else if (i_CE) r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // Two-flop synchroniser plus registered rising-edge detect on the push button
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_set_data};
      r_sync_d <= r_sync[1];
      r_edge   <= r_sync[1] & ~r_sync_d;
    end
  end

`ifdef CODE_PROG_EN
  logic [CW-1:0]  r_code, r_stage, w_stage;
  logic [DCW-1:0] r_pcnt, w_pcnt;
  logic           r_prog, w_prog_set, w_code_wr;
  assign w_code     = r_code;
  assign w_prog_led = r_prog;
`else
  assign w_code     = CODE;
  assign w_prog_led = 1'b0;
`endif

  always_comb begin
    w_nstate  = r_state;
    w_digits  = r_digits;
    w_cnt     = r_cnt;
    w_fail    = r_fail;
    w_tmr_clr = 1'b0;
    w_pause   = 1'b0;
`ifdef CODE_PROG_EN
    w_stage    = r_stage;
    w_pcnt     = r_pcnt;
    w_prog_set = 1'b0;
    w_code_wr  = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (r_edge) begin
        w_digits = (r_digits << DIGIT_W) | CW'(iv_data);
        w_cnt    = DCW'(1);
        w_nstate = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
      end
      S_ENTRY: begin
        // A full register waits one cycle here so the last thermometer step is shown
        if (r_cnt == DCW'(CODE_LEN)) w_nstate = S_CHECK;
        else if (r_edge) begin
          w_digits  = (r_digits << DIGIT_W) | CW'(iv_data);
          w_cnt     = r_cnt + 1'b1;
          w_tmr_clr = 1'b1;
        end else if (w_tick && r_tmr == TW'(TIMEOUT_TICKS - 1)) begin
          w_digits = '0;
          w_cnt    = '0;
          w_nstate = S_IDLE;
        end
      end
      S_CHECK: begin
        w_digits = '0;
        w_cnt    = '0;
        if (r_digits == w_code) begin
          w_fail   = '0;
          w_nstate = S_OPEN;
        end else begin
          w_fail   = r_fail + 1'b1;
          w_nstate = (w_fail == FCW'(MAX_FAIL)) ? S_LOCK : S_FAIL;
        end
      end
      S_OPEN: begin
`ifdef CODE_PROG_EN
        if (r_prog) begin
          w_pause = 1'b1;
          if (r_edge) begin
            w_stage = (r_stage << DIGIT_W) | CW'(iv_data);
            w_pcnt  = r_pcnt + 1'b1;
            if (r_pcnt == DCW'(CODE_LEN - 1)) begin
              w_code_wr = 1'b1;
              w_nstate  = S_IDLE;
            end
          end
        end else if (i_prog) begin
          w_pause    = 1'b1;
          w_prog_set = 1'b1;
        end else
`endif
        if (w_tick && r_tmr == TW'(OPEN_TICKS - 1)) w_nstate = S_IDLE;
      end
      S_FAIL: if (w_tick && r_tmr == TW'(FAIL_TICKS - 1)) w_nstate = S_IDLE;
      S_LOCK: if (w_tick && r_tmr == TW'(LOCKOUT_TICKS - 1)) begin
        w_fail   = '0;
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < 8; i++) w_therm[i] = (int'(r_cnt) > i);
  end

  always_ff @(posedge clk) begin
    if (i_Rst) begin
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_cnt    <= '0;
      r_fail   <= '0;
      r_tmr    <= '0;
      r_fph    <= 1'b0;
      r_ack    <= 8'h00;
      r_locked <= 1'b0;
      r_open   <= 1'b0;
      r_fail_q <= '0;
    end else begin
      r_state  <= w_nstate;
      r_digits <= w_digits;
      r_cnt    <= w_cnt;
      r_fail   <= w_fail;
      if (w_nstate != r_state || w_tmr_clr) r_tmr <= '0;
      else if (w_tick && !w_pause) r_tmr <= r_tmr + 1'b1;
      if (w_nstate != r_state) r_fph <= 1'b0;
      else if (r_state == S_FAIL && w_tick) r_fph <= ~r_fph;
      // Status outputs trail the state register by one cycle
      r_locked <= (r_state == S_LOCK);
      r_open   <= (r_state == S_OPEN);
      r_fail_q <= r_fail;
      case (r_state)
        S_IDLE:  r_ack <= 8'h00;
        S_ENTRY: r_ack <= w_therm;
        S_CHECK: r_ack <= r_ack;
        S_OPEN:  r_ack <= w_prog_led ? 8'h3C : 8'hFF;
        S_FAIL:  r_ack <= r_fph ? 8'h55 : 8'hAA;
        S_LOCK:  r_ack <= 8'hF0;
        default: r_ack <= 8'h00;
      endcase
    end
  end

`ifdef CODE_PROG_EN
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      r_code  <= CODE;
      r_stage <= '0;
      r_pcnt  <= '0;
      r_prog  <= 1'b0;
    end else begin
      r_stage <= w_prog_set ? '0 : w_stage;
      r_pcnt  <= w_prog_set ? '0 : w_pcnt;
      if (w_code_wr) r_code <= w_stage;
      if (w_prog_set) r_prog <= 1'b1;
      else if (w_nstate != r_state) r_prog <= 1'b0;
    end
  end
`endif

  assign o_acknowledge = r_ack;
  assign o_locked      = r_locked;
  assign o_open        = r_open;
  assign ov_fail_cnt   = r_fail_q;
endmodule
